amp_pwr_seq: RTL and testbench
==============================

// Module: amp_pwr_seq
// PURPOSE
//  Parametrised power-up/fault sequencer for NUM_AMP class-D amplifiers; replaces the single-timer sht_dwn logic in Equalizer.
//  Holds all amps in shutdown until the low-freq queues report full, waits PWRUP_CYC, then releases the amps one at a time.
//  Filters per-amp Flt_n and shuts every amp down on any fault; mute gates spkr_drv while the amps are not running.
// PARAMETERS
//  NUM_AMP      2        number of amplifiers (>=1)
//  PWRUP_CYC    250000   clk cycles spent in WAIT before the first release
//  STAGGER_CYC  1000     clk cycles between successive amp releases
//  FLT_FILT     4        consecutive synced-low samples needed to declare a fault (>=1)
//  RETRY_CYC    2500000  backoff length, used only with PWR_SEQ_RETRY_EN
//  MAX_RETRY    3        retries allowed before LOCKOUT, used only with PWR_SEQ_RETRY_EN
// PORTS
//  clk         in   1                   system clock, 50MHz
//  rst_n       in   1                   reset, asynchronous, active-low
//  q_full      in   1                   low-freq queues full (from EQ_engine); level signal
//  Flt_n       in   NUM_AMP             per-amp fault, active low, asynchronous to clk
//  sht_dwn     out  NUM_AMP             per-amp shutdown, 1 = amp held off
//  mute        out  1                   1 = spkr_drv outputs silence
//  flt_sticky  out  NUM_AMP             per-amp latched filtered-fault flag
//  retry_cnt   out  $clog2(MAX_RETRY+1) retries consumed so far
//  state       out  3                   current FSM state, encoded as listed below
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, sht_dwn all 1, mute=1, flt_sticky=0, retry_cnt=0, all counters and filters cleared.
//  All outputs are registered.
//  Flt_n: 2-flop synchroniser per bit, then a per-bit saturating counter.
//   - The counter increments on each synced-low sample and clears on any synced-high sample.
//   - flt[i] asserts when the counter reaches FLT_FILT.
//   - Fault latency: with Flt_n held low, sht_dwn reads all 1 no later than FLT_FILT+3 edges after Flt_n falls.
//   - A low pulse shorter than FLT_FILT synced samples has no effect.
//  flt_sticky[i] sets on flt[i]; it clears only on reset.
//  Every state except RUN forces mute=1; RUN forces mute=0.
//  FSM states and transitions:
//   IDLE(0): sht_dwn all 1. q_full sampled 1 -> WAIT on the next edge.
//   WAIT(1): sht_dwn all 1.
//     - Counts exactly PWRUP_CYC cycles, then -> STAGGER.
//     - q_full is ignored once IDLE has been left.
//   STAGGER(2): on entry sht_dwn[0]<=0.
//     - Every STAGGER_CYC cycles the next index is released (amp k at k*STAGGER_CYC cycles after entry).
//     - One cycle after amp NUM_AMP-1 is released -> RUN.
//     - With NUM_AMP=1: a single STAGGER cycle, then RUN.
//   RUN(3): sht_dwn all 0, mute=0.
//   FAULT(4): entered from WAIT/STAGGER/RUN on any flt[i].
//     - sht_dwn all 1 on the same edge that enters FAULT.
//     - Stays exactly 1 cycle, then -> LOCKOUT or BACKOFF (see CONFIGURATION).
//   BACKOFF(5): sht_dwn all 1.
//   LOCKOUT(6): sht_dwn all 1. Terminal; exits only via rst_n.
//  Simultaneous events:
//   - A fault in the same cycle as a WAIT expiry or a stagger release: the fault wins and no amp is released.
//   - q_full and flt together in IDLE: IDLE ignores flt and moves to WAIT; the fault is then taken from WAIT.
//  Counter widths are $clog2(param+1). Counters never wrap; each is cleared on every state entry.
// CONFIGURATION
//  Macro PWR_SEQ_RETRY_EN.
//  Undefined: FAULT -> LOCKOUT unconditionally. retry_cnt stays 0. RETRY_CYC and MAX_RETRY are unused.
//  Defined:
//   - FAULT: if retry_cnt==MAX_RETRY -> LOCKOUT; else retry_cnt++ and -> BACKOFF.
//   - BACKOFF counts RETRY_CYC cycles. At expiry, if no flt[i] is active -> WAIT; otherwise the count restarts.
//   - Re-sequencing from WAIT does not require q_full again.
//   - retry_cnt clears only on reset.
// TESTING (bench params: NUM_AMP=2, PWRUP_CYC=100, STAGGER_CYC=10, FLT_FILT=4, RETRY_CYC=50, MAX_RETRY=2)
//  1. Power-up. Reset, q_full=0 for 500 cycles -> state=0, sht_dwn=2'b11, mute=1.
//     q_full sampled 1 at edge E -> state=1 after E; sht_dwn=2'b10 after E+100; sht_dwn=2'b00 after E+110; state=3, mute=0 after E+111.
//  2. Glitch rejection. In RUN, Flt_n[1] low for 3 cycles -> sht_dwn=2'b00, flt_sticky=0, state stays 3.
//  3. Fault to lockout (macro off). In RUN, Flt_n[1] held low -> within 7 edges sht_dwn=2'b11, mute=1, flt_sticky=2'b10, state=4 then 6.
//     Release Flt_n and toggle q_full -> remains 6 until rst_n.
//  4. Retry path (macro on).
//     - Fault, then Flt_n released -> state 5 for 50 cycles, then 1, retry_cnt=1, full re-sequence to RUN with no q_full.
//     - Second fault -> retry_cnt=2.
//     - Third fault -> state=6, retry_cnt stays 2.
//  5. Persistent fault (macro on). Flt_n[0] held low through BACKOFF expiry -> state stays 5 and the count restarts.
//     Release Flt_n -> state=1 after the next 50-cycle expiry.
//  6. Reset mid-STAGGER. Assert rst_n=0 at E+105 -> sht_dwn=2'b11, mute=1, state=0 without a clk edge.
//     Deassert with q_full=1 -> sequence from test 1 repeats.

Source files
------------

// File: rtl/amp_pwr_seq.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// amp_pwr_seq
//   Power-up / fault sequencer for NUM_AMP class-D amplifiers.
//   Holds every amp in shutdown until the low-frequency queues report full.
//   It then waits PWRUP_CYC cycles and releases the amps one at a time,
//   STAGGER_CYC cycles apart.
//   Each Flt_n input is synchronised and filtered. Any filtered fault shuts
//   every amp down. mute silences spkr_drv whenever the amps are not running.
//
//   Build option: macro PWR_SEQ_RETRY_EN.
//     Undefined - a fault always ends in LOCKOUT, which only reset leaves.
//     Defined   - a fault goes through BACKOFF and re-sequences, up to
//                 MAX_RETRY times, before LOCKOUT.
//
// Ports
//   clk         in   system clock
//   rst_n       in   asynchronous, active-low reset
//   q_full      in   low-frequency queues full (level)
//   Flt_n       in   per-amp fault, active low, asynchronous to clk
//   sht_dwn     out  per-amp shutdown, 1 = amp held off
//   mute        out  1 = speaker drive outputs silence
//   flt_sticky  out  per-amp latched filtered-fault flag
//   retry_cnt   out  retries consumed so far
//   state       out  FSM state: IDLE=0 WAIT=1 STAGGER=2 RUN=3 FAULT=4
//                    BACKOFF=5 LOCKOUT=6
// ---------------------------------------------------------------------------
module amp_pwr_seq #(
  parameter int NUM_AMP     = 2,
  parameter int PWRUP_CYC   = 250000,
  parameter int STAGGER_CYC = 1000,
  parameter int FLT_FILT    = 4,
  parameter int RETRY_CYC   = 2500000,
  parameter int MAX_RETRY   = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           q_full,
  input  logic [NUM_AMP-1:0]             Flt_n,
  output logic [NUM_AMP-1:0]             sht_dwn,
  output logic                           mute,
  output logic [NUM_AMP-1:0]             flt_sticky,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt,
  output logic [2:0]                     state
);

  localparam int PW  = $clog2(PWRUP_CYC + 1);
  localparam int SW  = $clog2(STAGGER_CYC + 1);
  localparam int BW  = $clog2(RETRY_CYC + 1);
  localparam int FW  = $clog2(FLT_FILT + 1);
  localparam int AW  = $clog2(NUM_AMP + 1);
  localparam int RTW = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    STAGGER = 3'd2,
    RUN     = 3'd3,
    FAULT   = 3'd4,
    BACKOFF = 3'd5,
    LOCKOUT = 3'd6
  } state_t;

  state_t             state_q;
  logic [NUM_AMP-1:0] sht_q;
  logic               mute_q;
  logic [NUM_AMP-1:0] sticky_q;
  logic [RTW-1:0]     retry_q;
  logic [PW-1:0]      wait_cnt_q;
  logic [SW-1:0]      stg_cnt_q;
  logic [BW-1:0]      bo_cnt_q;
  logic [AW-1:0]      amp_idx_q;   // index of the most recently released amp

  logic [NUM_AMP-1:0] sync1_q, sync2_q;
  logic [NUM_AMP-1:0] flt;

  // Two-flop synchroniser. Reset to 1 so reset never looks like a fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= Flt_n;
      sync2_q <= sync1_q;
    end
  end

  // Per-amp saturating filter. flt is decoded straight from the counter
  // register, so a held-low Flt_n reaches sht_dwn FLT_FILT+3 edges after
  // it falls.
  generate
    for (genvar gi = 0; gi < NUM_AMP; gi++) begin : g_filt
      logic [FW-1:0] filt_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          filt_q <= '0;
        else if (sync2_q[gi])
          filt_q <= '0;
        else if (filt_q != FW'(FLT_FILT))
          filt_q <= filt_q + 1'b1;
      end
      assign flt[gi] = (filt_q == FW'(FLT_FILT));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sticky_q <= '0;
    else
      sticky_q <= sticky_q | flt;
  end

  // Sequencer. Each state's counter is cleared on the way out, so every
  // counter is zero whenever a state is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sht_q      <= '1;
      mute_q     <= 1'b1;
      retry_q    <= '0;
      wait_cnt_q <= '0;
      stg_cnt_q  <= '0;
      bo_cnt_q   <= '0;
      amp_idx_q  <= '0;
    end else begin
      case (state_q)
        // Faults are ignored here; they are picked up once in WAIT.
        IDLE: begin
          sht_q  <= '1;
          mute_q <= 1'b1;
          if (q_full)
            state_q <= WAIT;
        end
        WAIT: begin
          if (|flt) begin
            state_q    <= FAULT;
            sht_q      <= '1;
            mute_q     <= 1'b1;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q == PW'(PWRUP_CYC - 1)) begin
            state_q    <= STAGGER;
            sht_q      <= ~NUM_AMP'(1);  // amp 0 released on entry
            wait_cnt_q <= '0;
            amp_idx_q  <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        // The fault check comes first, so a fault in the same cycle as a
        // release wins and nothing is released.
        STAGGER: begin
          if (|flt) begin
            state_q   <= FAULT;
            sht_q     <= '1;
            mute_q    <= 1'b1;
            stg_cnt_q <= '0;
            amp_idx_q <= '0;
          end else if (amp_idx_q == AW'(NUM_AMP - 1)) begin
            state_q   <= RUN;
            sht_q     <= '0;
            mute_q    <= 1'b0;
            stg_cnt_q <= '0;
            amp_idx_q <= '0;
          end else if (stg_cnt_q == SW'(STAGGER_CYC - 1)) begin
            sht_q     <= sht_q & ~(NUM_AMP'(1) << (amp_idx_q + 1'b1));
            amp_idx_q <= amp_idx_q + 1'b1;
            stg_cnt_q <= '0;
          end else begin
            stg_cnt_q <= stg_cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (|flt) begin
            state_q <= FAULT;
            sht_q   <= '1;
            mute_q  <= 1'b1;
          end else begin
            sht_q  <= '0;
            mute_q <= 1'b0;
          end
        end
        FAULT: begin
          sht_q  <= '1;
          mute_q <= 1'b1;
`ifdef PWR_SEQ_RETRY_EN
          if (retry_q == RTW'(MAX_RETRY)) begin
            state_q <= LOCKOUT;
          end else begin
            retry_q <= retry_q + 1'b1;
            state_q <= BACKOFF;
          end
`else
          state_q <= LOCKOUT;
`endif
        end
        // A fault still present at expiry restarts the backoff window.
        // Re-sequencing goes straight to WAIT without needing q_full.
        BACKOFF: begin
          sht_q  <= '1;
          mute_q <= 1'b1;
          if (bo_cnt_q == BW'(RETRY_CYC - 1)) begin
            bo_cnt_q <= '0;
            if (~|flt)
              state_q <= WAIT;
          end else begin
            bo_cnt_q <= bo_cnt_q + 1'b1;
          end
        end
        LOCKOUT: begin
          sht_q  <= '1;
          mute_q <= 1'b1;
        end
        default: begin
          state_q <= LOCKOUT;
          sht_q   <= '1;
          mute_q  <= 1'b1;
        end
      endcase
    end
  end

  assign sht_dwn    = sht_q;
  assign mute       = mute_q;
  assign flt_sticky = sticky_q;
  assign retry_cnt  = retry_q;
  assign state      = state_q;

endmodule

// File: tb/tb_amp_pwr_seq.sv
`timescale 1ns/1ps
// Testbench for amp_pwr_seq. Build with +define+PWR_SEQ_RETRY_EN to exercise
// the retry / backoff paths instead of the lockout path.
module tb_amp_pwr_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       q_full = 1'b0;
  logic [1:0] Flt_n = 2'b11;
  logic [1:0] sht_dwn;
  logic       mute;
  logic [1:0] flt_sticky;
  logic [1:0] retry_cnt;
  logic [2:0] state;

  amp_pwr_seq #(
    .NUM_AMP(2), .PWRUP_CYC(100), .STAGGER_CYC(10),
    .FLT_FILT(4), .RETRY_CYC(50), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .q_full(q_full), .Flt_n(Flt_n),
    .sht_dwn(sht_dwn), .mute(mute), .flt_sticky(flt_sticky),
    .retry_cnt(retry_cnt), .state(state)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed vector: {state, sht_dwn, mute, flt_sticky, retry_cnt}
  logic [9:0] obs;
  assign obs = {state, sht_dwn, mute, flt_sticky, retry_cnt};

  typedef struct {
    int         cyc;
    logic [9:0] vec;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [9:0] mk(int st, logic [1:0] sh, logic m, logic [1:0] sk, int rc);
    return {st[2:0], sh, m, sk, rc[1:0]};
  endfunction

  task automatic push(int c, logic [9:0] v, string n);
    exp_t e;
    e.cyc = c; e.vec = v; e.name = n;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    int   c, guard;
    rst_n = 1'b0; q_full = 1'b0; Flt_n = 2'b11;
    #2;
    push(cyc, mk(0, 2'b11, 1'b1, 2'b00, 0), "reset_async");
    e = exp_q.pop_front(); checks++;
    if (obs !== e.vec) begin
      errors++; $display("FAIL %s: got %b want %b", e.name, obs, e.vec);
    end else $display("ok   %s: obs=%b", e.name, obs);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; c = cyc;
    push(c + 1,   mk(0, 2'b11, 1'b1, 2'b00, 0), "idle_1");
    push(c + 250, mk(0, 2'b11, 1'b1, 2'b00, 0), "idle_250");
    push(c + 500, mk(0, 2'b11, 1'b1, 2'b00, 0), "idle_500");
    guard = 0;
    while (exp_q.size() != 0 && guard < 700) begin
      @(negedge clk); guard++;
      while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front(); checks++;
        if (e.cyc != cyc || obs !== e.vec) begin
          errors++; $display("FAIL %s: cyc=%0d got %b want %b (due %0d)", e.name, cyc, obs, e.vec, e.cyc);
        end else $display("ok   %s: cyc=%0d obs=%b", e.name, cyc, obs);
      end
    end
    if (exp_q.size() != 0) begin
      checks++; errors++; $display("FAIL reset_drain: timeout got %0d pending want 0", exp_q.size()); exp_q.delete();
    end
  endtask

  // Releases rst_n (if held) with q_full=1 and checks the full power-up.
  task automatic test_powerup();
    exp_t e;
    int   e0, guard;
    @(negedge clk);
    rst_n = 1'b1; q_full = 1'b1; e0 = cyc + 1;
    push(e0,       mk(1, 2'b11, 1'b1, 2'b00, 0), "wait_entry");
    push(e0 + 99,  mk(1, 2'b11, 1'b1, 2'b00, 0), "wait_last");
    push(e0 + 100, mk(2, 2'b10, 1'b1, 2'b00, 0), "stagger_amp0");
    push(e0 + 109, mk(2, 2'b10, 1'b1, 2'b00, 0), "stagger_hold");
    push(e0 + 110, mk(2, 2'b00, 1'b1, 2'b00, 0), "stagger_amp1");
    push(e0 + 111, mk(3, 2'b00, 1'b0, 2'b00, 0), "run_entry");
    push(e0 + 120, mk(3, 2'b00, 1'b0, 2'b00, 0), "run_hold");
    guard = 0;
    while (exp_q.size() != 0 && guard < 400) begin
      @(negedge clk); guard++;
      if (cyc == e0)      q_full = 1'b0;
      if (cyc == e0 + 50) q_full = 1'b1;  // ignored outside IDLE
      if (cyc == e0 + 52) q_full = 1'b0;
      while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front(); checks++;
        if (e.cyc != cyc || obs !== e.vec) begin
          errors++; $display("FAIL %s: cyc=%0d got %b want %b (due %0d)", e.name, cyc, obs, e.vec, e.cyc);
        end else $display("ok   %s: cyc=%0d obs=%b", e.name, cyc, obs);
      end
    end
    if (exp_q.size() != 0) begin
      checks++; errors++; $display("FAIL powerup_drain: timeout got %0d pending want 0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_glitch();
    exp_t e;
    int   c, guard;
    @(negedge clk);
    Flt_n = 2'b01; c = cyc;
    push(c + 3,  mk(3, 2'b00, 1'b0, 2'b00, 0), "glitch_3");
    push(c + 6,  mk(3, 2'b00, 1'b0, 2'b00, 0), "glitch_6");
    push(c + 9,  mk(3, 2'b00, 1'b0, 2'b00, 0), "glitch_9");
    push(c + 14, mk(3, 2'b00, 1'b0, 2'b00, 0), "glitch_14");
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk); guard++;
      if (cyc == c + 3) Flt_n = 2'b11;
      while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front(); checks++;
        if (e.cyc != cyc || obs !== e.vec) begin
          errors++; $display("FAIL %s: cyc=%0d got %b want %b (due %0d)", e.name, cyc, obs, e.vec, e.cyc);
        end else $display("ok   %s: cyc=%0d obs=%b", e.name, cyc, obs);
      end
    end
    if (exp_q.size() != 0) begin
      checks++; errors++; $display("FAIL glitch_drain: timeout got %0d pending want 0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_lockout();
    exp_t e;
    int   c, guard;
    @(negedge clk);
    Flt_n = 2'b01; c = cyc;
    push(c + 6,  mk(3, 2'b00, 1'b0, 2'b00, 0), "pre_fault");
    push(c + 7,  mk(4, 2'b11, 1'b1, 2'b10, 0), "fault_entry");
    push(c + 8,  mk(6, 2'b11, 1'b1, 2'b10, 0), "lockout_entry");
    push(c + 20, mk(6, 2'b11, 1'b1, 2'b10, 0), "lockout_qfull");
    push(c + 40, mk(6, 2'b11, 1'b1, 2'b10, 0), "lockout_hold");
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk); guard++;
      if (cyc == c + 10) Flt_n = 2'b11;
      if (cyc == c + 12) q_full = 1'b1;
      if (cyc == c + 15) q_full = 1'b0;
      if (cyc == c + 25) q_full = 1'b1;
      if (cyc == c + 30) q_full = 1'b0;
      while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front(); checks++;
        if (e.cyc != cyc || obs !== e.vec) begin
          errors++; $display("FAIL %s: cyc=%0d got %b want %b (due %0d)", e.name, cyc, obs, e.vec, e.cyc);
        end else $display("ok   %s: cyc=%0d obs=%b", e.name, cyc, obs);
      end
    end
    if (exp_q.size() != 0) begin
      checks++; errors++; $display("FAIL lockout_drain: timeout got %0d pending want 0", exp_q.size()); exp_q.delete();
    end
  endtask

  // Starts a power-up from IDLE and pulls rst_n low in the middle of STAGGER.
  task automatic test_mid_stagger_reset();
    exp_t e;
    int   e0, guard;
    @(negedge clk);
    q_full = 1'b1; e0 = cyc + 1;
    push(e0 + 100, mk(2, 2'b10, 1'b1, 2'b00, 0), "mid_stagger_100");
    push(e0 + 105, mk(2, 2'b10, 1'b1, 2'b00, 0), "mid_stagger_105");
    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(negedge clk); guard++;
      if (cyc == e0) q_full = 1'b0;
      while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front(); checks++;
        if (e.cyc != cyc || obs !== e.vec) begin
          errors++; $display("FAIL %s: cyc=%0d got %b want %b (due %0d)", e.name, cyc, obs, e.vec, e.cyc);
        end else $display("ok   %s: cyc=%0d obs=%b", e.name, cyc, obs);
      end
    end
    if (exp_q.size() != 0) begin
      checks++; errors++; $display("FAIL mid_stagger_drain: timeout got %0d pending want 0", exp_q.size()); exp_q.delete();
    end
    // Reset between clock edges: outputs must change without a clk edge.
    rst_n = 1'b0; q_full = 1'b1;
    #1;
    push(cyc, mk(0, 2'b11, 1'b1, 2'b00, 0), "async_reset_mid_stagger");
    e = exp_q.pop_front(); checks++;
    if (obs !== e.vec) begin
      errors++; $display("FAIL %s: got %b want %b", e.name, obs, e.vec);
    end else $display("ok   %s: obs=%b", e.name, obs);
  endtask

`ifdef PWR_SEQ_RETRY_EN
  task automatic test_retry();
    exp_t e;
    int   c, w, guard;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      Flt_n = 2'b01; c = cyc;
      push(c + 6, mk(3, 2'b00, 1'b0, (k == 0) ? 2'b00 : 2'b10, k), "retry_pre_fault");
      push(c + 7, mk(4, 2'b11, 1'b1, 2'b10, k), "retry_fault");
      if (k < 2) begin
        w = c + 58;
        push(c + 8,   mk(5, 2'b11, 1'b1, 2'b10, k + 1), "backoff_entry");
        push(c + 57,  mk(5, 2'b11, 1'b1, 2'b10, k + 1), "backoff_last");
        push(w,       mk(1, 2'b11, 1'b1, 2'b10, k + 1), "rewait_entry");
        push(w + 99,  mk(1, 2'b11, 1'b1, 2'b10, k + 1), "rewait_last");
        push(w + 100, mk(2, 2'b10, 1'b1, 2'b10, k + 1), "restagger_amp0");
        push(w + 110, mk(2, 2'b00, 1'b1, 2'b10, k + 1), "restagger_amp1");
        push(w + 111, mk(3, 2'b00, 1'b0, 2'b10, k + 1), "rerun_entry");
      end else begin
        push(c + 8,  mk(6, 2'b11, 1'b1, 2'b10, 2), "retry_lockout");
        push(c + 30, mk(6, 2'b11, 1'b1, 2'b10, 2), "retry_lockout_hold");
      end
      guard = 0;
      while (exp_q.size() != 0 && guard < 400) begin
        @(negedge clk); guard++;
        if (cyc == c + 7) Flt_n = 2'b11;
        while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
          e = exp_q.pop_front(); checks++;
          if (e.cyc != cyc || obs !== e.vec) begin
            errors++; $display("FAIL %s: k=%0d cyc=%0d got %b want %b (due %0d)", e.name, k, cyc, obs, e.vec, e.cyc);
          end else $display("ok   %s: k=%0d cyc=%0d obs=%b", e.name, k, cyc, obs);
        end
      end
      if (exp_q.size() != 0) begin
        checks++; errors++; $display("FAIL retry_drain: timeout got %0d pending want 0", exp_q.size()); exp_q.delete();
      end
    end
  endtask

  task automatic test_persistent();
    exp_t e;
    int   c, guard;
    @(negedge clk);
    Flt_n = 2'b10; c = cyc;
    push(c + 7,   mk(4, 2'b11, 1'b1, 2'b01, 0), "persist_fault");
    push(c + 8,   mk(5, 2'b11, 1'b1, 2'b01, 1), "persist_backoff");
    push(c + 58,  mk(5, 2'b11, 1'b1, 2'b01, 1), "persist_restart");
    push(c + 107, mk(5, 2'b11, 1'b1, 2'b01, 1), "persist_second_last");
    push(c + 108, mk(1, 2'b11, 1'b1, 2'b01, 1), "persist_rewait");
    push(c + 110, mk(1, 2'b11, 1'b1, 2'b01, 1), "persist_wait_hold");
    guard = 0;
    while (exp_q.size() != 0 && guard < 300) begin
      @(negedge clk); guard++;
      if (cyc == c + 60) Flt_n = 2'b11;
      while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front(); checks++;
        if (e.cyc != cyc || obs !== e.vec) begin
          errors++; $display("FAIL %s: cyc=%0d got %b want %b (due %0d)", e.name, cyc, obs, e.vec, e.cyc);
        end else $display("ok   %s: cyc=%0d obs=%b", e.name, cyc, obs);
      end
    end
    if (exp_q.size() != 0) begin
      checks++; errors++; $display("FAIL persist_drain: timeout got %0d pending want 0", exp_q.size()); exp_q.delete();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_powerup();
    test_glitch();
`ifdef PWR_SEQ_RETRY_EN
    test_retry();
`else
    test_lockout();
`endif
    test_reset();
    test_mid_stagger_reset();
    test_powerup();
`ifdef PWR_SEQ_RETRY_EN
    test_persistent();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
